// File: rtl/r_row_dot.sv
// rtl/r_row_dot.sv - dot product of up to 8 RAM_R rows with a latched 8-element signed vector
module r_row_dot #(
    parameter int DW = 16,
    parameter int AW = 6,
    parameter int RW = 2*DW+3
) (
    input  logic            CK,
    input  logic            RST_N,
    input  logic            start,
    input  logic [3:0]      row_cnt,
    input  logic [8*DW-1:0] x_vec,
    output logic [AW-1:0]   ram_A,
    output logic            ram_OE,
    output logic            ram_WE,
    input  logic [8*DW-1:0] ram_Q,
    output logic [RW-1:0]   res_data,
    output logic [2:0]      res_row,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_READ, S_SUM, S_OUT, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             row_q, row_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [8*DW-1:0]        x_q, x_d;
    logic signed [2*DW-1:0] prod_q [8];
    logic signed [2*DW-1:0] prod_d [8];
    logic [RW-1:0]          res_data_q, res_data_d;
    logic [2:0]             res_row_q, res_row_d;
    logic                   res_valid_q, res_valid_d;
    logic [AW-1:0]          ram_a_q, ram_a_d;
    logic                   ram_oe_q, ram_oe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic signed [RW-1:0]   acc;

    function automatic logic signed [2*DW-1:0] sext(input logic [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        prod_d      = prod_q;
        res_data_d  = res_data_q;
        res_row_d   = res_row_q;
        res_valid_d = res_valid_q;

        // Each product fits 2*DW bits; three guard bits absorb the 8-way sum.
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + {{(RW-2*DW){prod_q[i][2*DW-1]}}, prod_q[i]};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (row_cnt == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        x_d     = x_vec;
                        cnt_d   = (row_cnt > 4'd8) ? 4'd8 : row_cnt;
                        row_d   = 3'd0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_READ;
            S_READ: begin
                for (int i = 0; i < 8; i++) begin
                    prod_d[i] = sext(ram_Q[DW*i +: DW]) * sext(x_q[DW*i +: DW]);
                end
                state_d = S_SUM;
            end
            S_SUM: begin
                res_data_d  = acc;
                res_row_d   = row_q;
                res_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if ({1'b0, row_q} + 4'd1 == cnt_q) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        ram_oe_d = (state_d == S_ISSUE) || (state_d == S_READ);
        ram_a_d  = ram_oe_d ? AW'(row_d) : '0;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            for (int i = 0; i < 8; i++) prod_q[i] <= '0;
            res_data_q  <= '0;
            res_row_q   <= '0;
            res_valid_q <= 1'b0;
            ram_a_q     <= '0;
            ram_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            for (int i = 0; i < 8; i++) prod_q[i] <= prod_d[i];
            res_data_q  <= res_data_d;
            res_row_q   <= res_row_d;
            res_valid_q <= res_valid_d;
            ram_a_q     <= ram_a_d;
            ram_oe_q    <= ram_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ram_A     = ram_a_q;
    assign ram_OE    = ram_oe_q;
    assign ram_WE    = 1'b0;
    assign res_data  = res_data_q;
    assign res_row   = res_row_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/r_row_dot.md
R_ROW_DOT -- requirements
Module: r_row_dot

Interface
REQ-001 SHALL have parameter DW, default 16: width of one signed RAM_R word.
REQ-002 SHALL have parameter AW, default 6: RAM_R address width.
REQ-003 SHALL have parameter RW, default 2*DW+3: width of the signed result.
REQ-004 SHALL have port CK, input, 1: the single clock; all state updates on posedge.
REQ-005 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: single-cycle request to begin a job.
REQ-007 SHALL have port row_cnt, input, 4: number of rows to process, sampled with start.
REQ-008 SHALL have port x_vec, input, 8*DW: 8 signed vector elements; element i in bits [DW*(i+1)-1 -: DW]; sampled with start.
REQ-009 SHALL have port ram_A, output, AW: row address driven to RAM_R.
REQ-010 SHALL have port ram_OE, output, 1: RAM_R output enable.
REQ-011 SHALL have port ram_WE, output, 1: RAM_R write enable, constant 0.
REQ-012 SHALL have port ram_Q, input, 8*DW: 8-word row from RAM_R, valid one cycle after ram_A is sampled with ram_OE=1.
REQ-013 SHALL have port res_data, output, RW: signed dot product of the current row with x_vec.
REQ-014 SHALL have port res_row, output, 3: row index of res_data.
REQ-015 SHALL have port res_valid, output, 1: result valid.
REQ-016 SHALL have port res_ready, input, 1: downstream accepts the result.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at job end.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, READ, SUM, OUT and DONE.
REQ-020 IDLE: when start=1 and row_cnt is 1..8, SHALL latch x_vec and min(row_cnt,8), clear row to 0, and enter ISSUE.
REQ-021 IDLE: start with row_cnt=0 SHALL go directly to DONE with no RAM access; row_cnt 9..15 SHALL be clamped to 8.
REQ-022 ISSUE: SHALL drive ram_A=row (zero-extended) and ram_OE=1, then enter READ.
REQ-023 READ: SHALL hold ram_OE=1, register the 8 signed products ram_Q[i]*x[i] (2*DW bits each), then enter SUM.
REQ-024 SUM: SHALL register the sign-extended full-precision sum of the 8 products into res_data and row into res_row, set res_valid=1, then enter OUT; there SHALL be no saturation and no rounding.
REQ-025 OUT: SHALL hold res_valid, res_data and res_row stable until res_valid&res_ready is seen at a posedge.
REQ-026 OUT handshake: SHALL clear res_valid; if row+1 equals the latched count SHALL enter DONE, else SHALL increment row and enter ISSUE.
REQ-027 DONE: SHALL assert done for exactly one cycle, then enter IDLE.
REQ-028 ram_OE SHALL be 0 in all states except ISSUE and READ; ram_A SHALL be 0 in IDLE.
REQ-029 start while busy=1 SHALL be ignored and SHALL NOT alter the latched x_vec or count.
REQ-030 Latency: res_valid SHALL rise after the 4th posedge counting the start-sampling edge as edge 1; with res_ready held at 1, rows SHALL issue every 4 cycles.
REQ-031 res_ready while res_valid=0 SHALL have no effect.

Reset
REQ-032 RST_N=0 SHALL immediately force state=IDLE, row=0, ram_A=0, ram_OE=0, res_valid=0, res_data=0, res_row=0, busy=0 and done=0, asynchronously.
REQ-033 Reset asserted mid-job SHALL abandon the job; no done pulse and no further results SHALL follow release.
REQ-034 After RST_N rises, the first posedge SHALL be able to accept start.

Verification
REQ-035 Scenario: RAM row 0 = 1..8, x = all 1, row_cnt=1, res_ready=1 -> ram_A=0 with OE, res_data=36, res_row=0, done one cycle after handshake.
REQ-036 Scenario: row 2 words all -32768, x all -32768, row_cnt=3 -> row 2 res_data=+8*2^30 (0x200000000), no overflow at RW=35.
REQ-037 Scenario: row_cnt=8, res_ready stalled 5 cycles on row 3 -> res_data/res_row stable throughout, rows 0..7 each delivered exactly once, in order.
REQ-038 Scenario: row_cnt=0 -> done pulse 2 cycles after start, ram_OE never 1; row_cnt=12 -> exactly 8 results.
REQ-039 Scenario: start pulsed in SUM with different x_vec -> ignored; results use the original x.
REQ-040 Scenario: RST_N low during OUT of row 4 -> res_valid=0 immediately, busy=0, no done; a new job then runs cleanly from row 0.
